// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding of the cla_4_bit slice, slice width
// and the sequencer state type.
package alu_pkg;

  localparam int ALUOP_W = 3;
  localparam int SLICE_W = 4;

  localparam logic [ALUOP_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALUOP_W-1:0] ALU_NOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/response bus of alu_slice_sequencer. The rsp_zero signal exists only
// when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_slice_sequencer_if #(
  parameter int WIDTH = 16
) ();
  import alu_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [ALUOP_W-1:0] req_op;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic               rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zero
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_cout
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_cout
  );
`endif

endinterface

// File: rtl/cla_4_bit.sv
// 4-bit carry-lookahead ALU slice. Logic ops report c_out=0; SUB inverts b and
// relies on the caller to supply c_in=1 for two's complement.
module cla_4_bit
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] ALUop,
  input  logic [3:0]         a,
  input  logic [3:0]         b,
  input  logic               c_in,
  output logic [3:0]         result,
  output logic               c_out
);

  logic [3:0] bb, p, g, c;
  logic       c4;

  always_comb begin
    bb = (ALUop == ALU_SUB) ? ~b : b;
    p  = a ^ bb;
    g  = a & bb;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);

    result = 4'h0;
    c_out  = 1'b0;
    case (ALUop)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD, ALU_SUB: begin
        result = p ^ c;
        c_out  = c4;
      end
      default: begin
        result = 4'h0;
        c_out  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Feeds one WIDTH-bit operation through a single cla_4_bit, one slice per cycle
// LSB first, chaining the carry in a register. Optional ALU_SEQ_ZERO_FLAG_EN adds rsp_zero.
module alu_slice_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_slice_sequencer_if.slave bus
);

  localparam int N_SLICES = WIDTH / SLICE_W;
  localparam int IDXW     = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_SLICES - 1);

  seq_state_e         state_q;
  logic [IDXW-1:0]    idx_q;
  logic [ALUOP_W-1:0] op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               carry_q;
  logic               rsp_valid_q;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_res;
  logic               slice_cout;

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  cla_4_bit u_slice (
    .ALUop  (op_q),
    .a      (slice_a),
    .b      (slice_b),
    .c_in   (carry_q),
    .result (slice_res),
    .c_out  (slice_cout)
  );

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zacc_q;
  assign bus.rsp_zero = zacc_q;

  // Zero flag accumulates alongside the slices, so no WIDTH-wide reduction is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_q <= 1'b0;
    end else if (state_q == IDLE && bus.req_valid) begin
      zacc_q <= 1'b1;
    end else if (state_q == RUN) begin
      zacc_q <= zacc_q & (slice_res == '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            carry_q <= bus.req_cin;
            idx_q   <= '0;
            res_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q[idx_q*SLICE_W +: SLICE_W] <= slice_res;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Result and carry simply stay put until the consumer takes them.
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign bus.req_ready  = rst_n & (state_q == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_cout   = carry_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench for alu_slice_sequencer (WIDTH=16); rsp_zero checked when
// ALU_SEQ_ZERO_FLAG_EN is defined.
module tb_alu_slice_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_slice_sequencer_if #(.WIDTH(16)) sif ();
  alu_slice_sequencer #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    chk("accept_ready", {31'd0, sif.req_ready}, 32'd1);
    sif.req_valid = 1'b1;
    sif.req_op    = op;
    sif.req_a     = a;
    sif.req_b     = b;
    sif.req_cin   = cin;
    tick();
    sif.req_valid = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; response due 4 edges later.
  task automatic finish_op(input string tag, input logic [15:0] er, input logic ec, input logic ez);
    tick();
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, sif.rsp_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, sif.rsp_valid}, 32'd1);
    chk({tag, "_result"}, {16'd0, sif.rsp_result}, {16'd0, er});
    chk({tag, "_cout"}, {31'd0, sif.rsp_cout}, {31'd0, ec});
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk({tag, "_zero"}, {31'd0, sif.rsp_zero}, {31'd0, ez});
`else
    if (ez === 1'bx) $display("unexpected x");
`endif
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    chk({tag, "_release"}, {31'd0, sif.rsp_valid}, 32'd0);
  endtask

  initial begin
    sif.req_valid = 1'b0;
    sif.req_op    = ALU_ADD;
    sif.req_a     = '0;
    sif.req_b     = '0;
    sif.req_cin   = 1'b0;
    sif.rsp_ready = 1'b0;

    #2;
    chk("rst_req_ready", {31'd0, sif.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("rst_result", {16'd0, sif.rsp_result}, 32'd0);
    chk("rst_cout", {31'd0, sif.rsp_cout}, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", {31'd0, sif.rsp_zero}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", {31'd0, sif.req_ready}, 32'd1);
    @(negedge clk);

    issue(ALU_ADD, 16'h1234, 16'h0FFF, 1'b0);
    finish_op("add_chain", 16'h2233, 1'b0, 1'b0);
    issue(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0);
    finish_op("add_wrap", 16'h0000, 1'b1, 1'b1);
    issue(ALU_SUB, 16'h5000, 16'h0001, 1'b1);
    finish_op("sub_noborrow", 16'h4FFF, 1'b1, 1'b0);
    issue(ALU_SUB, 16'h0000, 16'h0001, 1'b1);
    finish_op("sub_borrow", 16'hFFFF, 1'b0, 1'b0);
    issue(ALU_AND, 16'hF0F0, 16'hFF00, 1'b0);
    finish_op("and", 16'hF000, 1'b0, 1'b0);
    issue(ALU_XOR, 16'hAAAA, 16'hAAAA, 1'b0);
    finish_op("xor_zero", 16'h0000, 1'b0, 1'b1);

    // Backpressure: hold DONE for 5 cycles with a request pending.
    issue(ALU_ADD, 16'h00FF, 16'h0001, 1'b0);
    tick();
    tick();
    tick();
    tick();
    sif.req_valid = 1'b1;
    sif.req_op    = ALU_ADD;
    sif.req_a     = 16'h0003;
    sif.req_b     = 16'h0004;
    sif.req_cin   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, sif.rsp_valid}, 32'd1);
      chk("bp_result", {16'd0, sif.rsp_result}, 32'h0100);
      chk("bp_cout", {31'd0, sif.rsp_cout}, 32'd0);
      chk("bp_req_ready", {31'd0, sif.req_ready}, 32'd0);
      tick();
    end
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    chk("bp_idle_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, sif.req_ready}, 32'd1);
    tick();
    sif.req_valid = 1'b0;
    chk("bp_accepted", {31'd0, sif.req_ready}, 32'd0);
    finish_op("bp_next", 16'h0007, 1'b0, 1'b0);

    // Reset during slice 2.
    issue(ALU_ADD, 16'h1234, 16'h1111, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, sif.rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, sif.req_ready}, 32'd0);
    chk("mid_rst_result", {16'd0, sif.rsp_result}, 32'd0);
    chk("mid_rst_cout", {31'd0, sif.rsp_cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, sif.req_ready}, 32'd1);
    tick();
    chk("post_rst_valid", {31'd0, sif.rsp_valid}, 32'd0);
    issue(ALU_ADD, 16'h0001, 16'h0001, 1'b0);
    finish_op("post_rst_add", 16'h0002, 1'b0, 1'b0);

    // Operands toggled during RUN must not leak in.
    issue(ALU_ADD, 16'h1111, 16'h2222, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sif.req_a = 16'($urandom);
      sif.req_b = 16'($urandom);
      tick();
    end
    chk("toggle_valid", {31'd0, sif.rsp_valid}, 32'd1);
    chk("toggle_result", {16'd0, sif.rsp_result}, 32'h3333);
    chk("toggle_cout", {31'd0, sif.rsp_cout}, 32'd0);
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
